reel_speed_profile: RTL
=======================

// Module: reel_speed_profile
// PURPOSE
//  Generates the time-varying reel speed (ticks/s) that drives one reel's clockDivider.
//  On start: ramp up, cruise for a pseudo-random number of ramp intervals, ramp down, report done.
//  Speed is never 0, so the downstream divider never divides by zero.
//  Sits between the game controller (start/stop) and the per-reel clock divider.
// PARAMETERS
//  BASE_SPEED       50_000_000  clk frequency in Hz; sizes the ramp timer
//  MIN_SPEED        2           idle/stop speed in Hz; must be >= 1
//  MAX_SPEED        20          cruise speed in Hz; MIN_SPEED < MAX_SPEED <= BASE_SPEED/2
//  STEP             1           speed change per ramp tick, in Hz; must be >= 1
//  RAMP_TICKS       5_000_000   clk cycles per ramp tick (0.1 s at default)
//  CRUISE_MIN_STEPS 10          minimum cruise length in ramp ticks; must be >= 1
//  CRUISE_RAND_BITS 4           LFSR bits added to cruise length; range 1..8
// PORTS
//  clk       in   1   system clock, single domain
//  rst       in   1   synchronous reset, active-high
//  start     in   1   1-cycle pulse: begin a spin; honoured only in IDLE
//  stop_req  in   1   level or pulse: cut cruise short; honoured only in ACCEL/CRUISE
//  speed     out  32  current speed in Hz, to clockDivider.speed
//  spinning  out  1   high in ACCEL, CRUISE and DECEL
//  done      out  1   1-cycle pulse when the reel has settled (STOP state)
// BEHAVIOUR
//  Reset: state=IDLE, speed=MIN_SPEED, spinning=0, done=0, ramp_cnt=0, cruise_cnt=0, lfsr=16'hACE1.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk cycle, including in IDLE.
//    Player timing of start therefore sets the cruise length. State 0 is unreachable.
//  Ramp timer: ramp_cnt counts 0..RAMP_TICKS-1 while not IDLE/STOP.
//    tick = (ramp_cnt == RAMP_TICKS-1), then ramp_cnt wraps to 0.
//    ramp_cnt is cleared on IDLE->ACCEL and on ACCEL/CRUISE->DECEL.
//  speed changes only on tick cycles, so the divider sees a stable value between ticks.
//  FSM transitions (registered; outputs reflect the new state one cycle after the cause):
//   IDLE:   start -> ACCEL. speed=MIN_SPEED.
//           Latch cruise_len = CRUISE_MIN_STEPS + lfsr[CRUISE_RAND_BITS-1:0].
//   ACCEL:  stop_req -> DECEL; speed holds.
//           Else on tick: speed = min(speed+STEP, MAX_SPEED); new speed == MAX_SPEED -> CRUISE.
//           Clear cruise_cnt on entering CRUISE.
//   CRUISE: stop_req -> DECEL.
//           Else on tick: cruise_cnt++; when cruise_cnt == cruise_len-1 on a tick -> DECEL.
//   DECEL:  on tick: speed = max(speed-STEP, MIN_SPEED); new speed == MIN_SPEED -> STOP.
//   STOP:   done=1 for exactly this cycle; unconditional -> IDLE.
//  Arithmetic: add/subtract in 33 bits, then saturate. No wrap with STEP > MAX_SPEED-speed
//    or STEP > speed-MIN_SPEED.
//  Latency: start sampled at cycle N -> spinning=1 at N+1. First speed step at N+RAMP_TICKS.
//  Boundary conditions:
//   start outside IDLE: ignored, including during STOP.
//   start+stop_req together in IDLE: start wins; stop_req is ignored.
//   stop_req in DECEL, STOP or IDLE: no effect.
//   stop_req on the same cycle as a CRUISE timeout tick: single DECEL entry, no double action.
//   rst mid-spin: full reset next edge; done is not pulsed; speed returns to MIN_SPEED.
// STRUCTURE
//  slot_pkg: typedef enum logic [2:0] {IDLE,ACCEL,CRUISE,DECEL,STOP} reel_state_t;
//    localparam SPEED_W=32.
//  Sub-module lfsr16 (clk, rst, seed param, q[15:0]), free-running. Reused by other reels
//    with distinct seeds.
//  Remainder (FSM, ramp timer, cruise counter, saturating speed register) lives in this file.
// TESTING  (bench params: RAMP_TICKS=4, MIN_SPEED=2, MAX_SPEED=5, STEP=2,
//           CRUISE_MIN_STEPS=3, CRUISE_RAND_BITS=2)
//  1 Reset: hold rst 3 cycles -> speed=2, spinning=0, done=0.
//    Release; idle 20 cycles -> outputs unchanged.
//  2 Full spin, no stop_req: speed 2->4->5 (saturates; no 6 and no wrap), one step every 4 clks.
//    Cruise length = 3 + lfsr[1:0] from the bench LFSR model; then 5->3->2; done pulses once.
//  3 stop_req pulse during ACCEL at speed=4 -> DECEL next cycle; speed 4 holds 4 clks, then 2.
//    done pulses; MAX speed is never reached.
//  4 start pulsed during CRUISE and during STOP -> ignored.
//    start+stop_req together in IDLE -> spin begins normally.
//  5 rst asserted mid-DECEL at speed=3 -> next cycle IDLE, speed=2, spinning=0, no done pulse.
//    A new start then runs a full spin.
//  6 Assertions throughout: speed in [2,5] always; speed changes only on tick cycles;
//    done is a 1-cycle pulse; spinning==0 whenever done==1.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types for the slot-machine reel datapath.
// Holds the reel FSM state type and speed arithmetic helpers.
package slot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        CRUISE,
        DECEL,
        STOP
    } reel_state_t;

    localparam int SPEED_W = 32;

    typedef logic [SPEED_W-1:0] speed_t;

    // Widen by one bit so a large step can never wrap past the ceiling.
    function automatic speed_t sat_add(
        input speed_t v,
        input speed_t step,
        input speed_t hi
    );
        logic [SPEED_W:0] sum;
        sum = {1'b0, v} + {1'b0, step};
        return (sum > {1'b0, hi}) ? hi : sum[SPEED_W-1:0];
    endfunction

    // A borrow in the top bit means the result went negative.
    function automatic speed_t sat_sub(
        input speed_t v,
        input speed_t step,
        input speed_t lo
    );
        logic [SPEED_W:0] diff;
        diff = {1'b0, v} - {1'b0, step};
        if (diff[SPEED_W] || (diff < {1'b0, lo})) begin
            return lo;
        end
        return diff[SPEED_W-1:0];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Each reel instantiates one with its own non-zero seed.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

    // Shift right every cycle, feedback enters at the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {fb, q[15:1]};
        end
    end

endmodule

// File: rtl/reel_speed_profile.sv
// Reel speed profile: ramp up, cruise a random time, ramp down.
// Speed never drops below MIN_SPEED so the divider never sees 0.
module reel_speed_profile
    import slot_pkg::*;
#(
    parameter int BASE_SPEED       = 50_000_000,
    parameter int MIN_SPEED        = 2,
    parameter int MAX_SPEED        = 20,
    parameter int STEP             = 1,
    parameter int RAMP_TICKS       = 5_000_000,
    parameter int CRUISE_MIN_STEPS = 10,
    parameter int CRUISE_RAND_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop_req,
    output logic [SPEED_W-1:0] speed,
    output logic               spinning,
    output logic               done
);

    localparam int RAMP_SPAN =
        (BASE_SPEED > RAMP_TICKS) ? BASE_SPEED : RAMP_TICKS;
    localparam int RAMP_W = $clog2(RAMP_SPAN + 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);

    localparam int CR_MAX = CRUISE_MIN_STEPS + (1 << CRUISE_RAND_BITS);
    localparam int CR_W   = $clog2(CR_MAX + 1);

    localparam speed_t MIN_V  = SPEED_W'(MIN_SPEED);
    localparam speed_t MAX_V  = SPEED_W'(MAX_SPEED);
    localparam speed_t STEP_V = SPEED_W'(STEP);

    reel_state_t       state;
    logic [RAMP_W-1:0] ramp_cnt;
    logic [CR_W-1:0]   cruise_cnt;
    logic [CR_W-1:0]   cruise_len;
    logic [15:0]       lfsr_q;
    logic              tick;
    speed_t            speed_up;
    speed_t            speed_dn;
    logic              unused_lfsr;

    lfsr16 #(
        .SEED (16'hACE1)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q;
    assign tick        = (ramp_cnt == RAMP_LAST);

    // Candidate next speeds, saturated at the profile limits.
    always_comb begin
        speed_up = sat_add(speed, STEP_V, MAX_V);
        speed_dn = sat_sub(speed, STEP_V, MIN_V);
    end

    // Spin FSM with ramp timer, cruise counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            speed      <= MIN_V;
            spinning   <= 1'b0;
            done       <= 1'b0;
            ramp_cnt   <= '0;
            cruise_cnt <= '0;
            cruise_len <= '0;
        end else begin
            done <= 1'b0;
            if (state inside {ACCEL, CRUISE, DECEL}) begin
                ramp_cnt <= tick ? '0 : ramp_cnt + RAMP_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCEL;
                        speed      <= MIN_V;
                        spinning   <= 1'b1;
                        ramp_cnt   <= '0;
                        cruise_len <= CR_W'(CRUISE_MIN_STEPS)
                            + CR_W'(lfsr_q[CRUISE_RAND_BITS-1:0]);
                    end
                end
                ACCEL: begin
                    if (stop_req) begin
                        state    <= DECEL;
                        ramp_cnt <= '0;
                    end else if (tick) begin
                        speed <= speed_up;
                        if (speed_up == MAX_V) begin
                            state      <= CRUISE;
                            cruise_cnt <= '0;
                        end
                    end
                end
                CRUISE: begin
                    if (stop_req) begin
                        state    <= DECEL;
                        ramp_cnt <= '0;
                    end else if (tick) begin
                        cruise_cnt <= cruise_cnt + CR_W'(1);
                        if (cruise_cnt == cruise_len - CR_W'(1)) begin
                            state    <= DECEL;
                            ramp_cnt <= '0;
                        end
                    end
                end
                DECEL: begin
                    if (tick) begin
                        speed <= speed_dn;
                        if (speed_dn == MIN_V) begin
                            state    <= STOP;
                            spinning <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                STOP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
